multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select.
- Produces the 2-bit ALU operation class (00 add, 01 subtract, 10 R-type funct, 11 immediate opcode) consumed by the ALU control decoder. It is the producing end of that interface.

Parameters:
- OPW, 6, opcode width.
- MEM_WAIT, 1, 1 = FETCH/MEM_READ/MEM_WRITE hold until in_mem_ready; 0 = in_mem_ready ignored (single-cycle memory).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_opcode  in  6  IR[31:26]; stable from DECODE onward.
- in_zero  in  1  ALU zero flag.
- in_mem_ready  in  1  memory access complete this cycle.
- out_pc_write  out  1  PC load enable, including the branch-taken term.
- out_iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- out_mem_read  out  1  memory read strobe.
- out_mem_write  out  1  memory write strobe.
- out_ir_write  out  1  IR load enable.
- out_mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- out_reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- out_reg_write  out  1  register file write enable.
- out_alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A.
- out_alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- out_alu_op  out  2  ALU operation class (encoding in Overview).
- out_zero_ext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- out_pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- out_illegal  out  1  one-cycle pulse on an undecodable opcode.
- out_state  out  4  current state, for debug.

Behaviour:
- State register: 4 bits, async reset to FETCH (0).
- While rst = 1, every enable/strobe output is 0, selects are 0 and out_state = 0.
- Moore outputs are decoded combinationally from state, gated by ~rst.
- out_pc_write = pc_write_uncond | (state == BRANCH & in_zero).
- Default output values in every state: all enables 0, all selects 0, out_alu_op = 00.
- Per-state outputs and transitions:
  - FETCH (0): mem_read=1, iord=0, ir_write=ready, src_a=0, src_b=01, alu_op=00, pc_source=00, pc_write=ready. Goes to DECODE when ready, otherwise stays.
  - DECODE (1): src_a=0, src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw), 101011 (sw) -> MEM_ADDR
    - 000000 (R-type) -> R_EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi), 001100 (andi), 001101 (ori), 001110 (xori) -> I_EXEC
    - any other opcode -> FETCH, with out_illegal=1 for this cycle only.
  - MEM_ADDR (2): src_a=1, src_b=10, alu_op=00. Goes to MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ (3): mem_read=1, iord=1. Goes to MEM_WB when ready.
  - MEM_WB (4): reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEM_WRITE (5): mem_write=1, iord=1. Goes to FETCH when ready.
  - R_EXEC (6): src_a=1, src_b=00, alu_op=10. Goes to R_WB.
  - R_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH (8): src_a=1, src_b=00, alu_op=01, pc_source=01, pc_write=in_zero. Goes to FETCH.
  - JUMP (9): pc_source=10, pc_write=1. Goes to FETCH.
  - I_EXEC (10): src_a=1, src_b=10, alu_op=11, zero_ext=1 for andi/ori/xori and 0 for addi. Goes to I_WB.
  - I_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
  - States 12-15 (unreachable): outputs at defaults; next state FETCH.
- Cycle counts with no wait states: lw 5, sw 4, R-type 4, immediate 4, beq 3, j 3, illegal 2.
- Memory wait: each cycle with in_mem_ready=0 adds one cycle in the stalled state. During a stall, mem_read/mem_write stay asserted and pc_write/ir_write stay 0.
- Reset mid-instruction: state goes to FETCH immediately and no partial writeback occurs. The first fetch starts on the first rising edge after rst falls.
- in_zero is sampled only in BRANCH; in every other state out_pc_write is independent of in_zero.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI;
  - ALU operation class constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_IMM=11;
  - the 4-bit state enum;
  - the src_b and pc_source select encodings.
- One sub-module, mc_next_state: a combinational (state, opcode, ready) -> next-state function.
- Output decode stays in the top module.

Test Plan:
- rst=1 mid-MEM_READ -> out_state=0 immediately and all enables 0; after release, FETCH asserts mem_read=1, src_b=01, alu_op=00.
- opcode 000000, ready=1 -> states 0,1,6,7,0; alu_op=10 in R_EXEC; reg_write=1 with reg_dst=1 in R_WB only.
- opcode 100011, ready held 0 for 2 cycles in MEM_READ -> state 3 held 3 cycles with mem_read=1 and iord=1; MEM_WB then gives reg_write=1, mem_to_reg=1.
- opcode 000100: with in_zero=1 -> pc_write=1, pc_source=01, alu_op=01 in state 8; with in_zero=0 -> pc_write=0.
- opcode 001101 -> I_EXEC gives alu_op=11, src_b=10, zero_ext=1; opcode 001000 -> zero_ext=0; both then I_WB reg_write=1, reg_dst=0.
- opcode 111111 -> out_illegal=1 for exactly one cycle in DECODE; next state FETCH; no reg_write or mem_write asserted.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: opcodes, ALU class, states, mux encodings.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package multicycle_control_pkg;

    localparam int OPCODE_W = 6;

    // Instruction opcodes (IR[31:26])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;

    // ALU operation class handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control states; encodings 12-15 are never entered
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
        ST_I_WB      = 4'd11
    } state_t;

    // Immediate ALU instructions handled by I_EXEC/I_WB
    function automatic logic isImmOp(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

    // Logical immediates take a zero-extended operand; addi sign-extends
    function automatic logic isZeroExtOp(input logic [OPCODE_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

    function automatic logic isLegalOp(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || isImmOp(op);
    endfunction

endpackage

// File: rtl/multicycle_control_next_state.sv
// mc_next_state: combinational next-state function of the multicycle control FSM.
// Latency: zero (pure combinational).
// Backpressure: memory states hold while memReady is low.
//
// Ports:
//   curState  - present FSM state
//   opcode    - IR[31:26], valid from DECODE onward
//   memReady  - memory access completes this cycle (already forced high when wait states are off)
//   nextState - state to load on the next clock edge
module mc_next_state
    import multicycle_control_pkg::*;
(
    input  state_t                curState,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  memReady,
    output state_t                nextState
);

    always_comb begin
        nextState = ST_FETCH;
        case (curState)
            ST_FETCH: begin
                nextState = memReady ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    nextState = ST_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    nextState = ST_R_EXEC;
                end else if (opcode == OP_BEQ) begin
                    nextState = ST_BRANCH;
                end else if (opcode == OP_J) begin
                    nextState = ST_JUMP;
                end else if (isImmOp(opcode)) begin
                    nextState = ST_I_EXEC;
                end else begin
                    // undecodable opcode: abandon the instruction and refetch
                    nextState = ST_FETCH;
                end
            end
            ST_MEM_ADDR: begin
                // only lw/sw reach this state; anything but lw is treated as a store
                nextState = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                nextState = memReady ? ST_MEM_WB : ST_MEM_READ;
            end
            ST_MEM_WB: begin
                nextState = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                nextState = memReady ? ST_FETCH : ST_MEM_WRITE;
            end
            ST_R_EXEC: begin
                nextState = ST_R_WB;
            end
            ST_R_WB: begin
                nextState = ST_FETCH;
            end
            ST_BRANCH: begin
                nextState = ST_FETCH;
            end
            ST_JUMP: begin
                nextState = ST_FETCH;
            end
            ST_I_EXEC: begin
                nextState = ST_I_WB;
            end
            ST_I_WB: begin
                nextState = ST_FETCH;
            end
            default: begin
                nextState = ST_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw/R/imm 4, beq/j 3, illegal 2 cycles, plus one cycle per memory wait state.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold with strobes asserted until in_mem_ready (if MEM_WAIT).
//
// Ports:
//   clk, rst (async, active-high)       in_opcode, in_zero, in_mem_ready - datapath/memory status
//   out_pc_write, out_iord, out_mem_read, out_mem_write, out_ir_write    - PC / memory / IR control
//   out_mem_to_reg, out_reg_dst, out_reg_write                           - register file writeback
//   out_alu_src_a, out_alu_src_b, out_alu_op, out_zero_ext               - ALU operand/op control
//   out_pc_source, out_illegal, out_state                                - PC mux, illegal pulse, debug
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPW      = 6,
    parameter int MEM_WAIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] in_opcode,
    input  logic           in_zero,
    input  logic           in_mem_ready,
    output logic           out_pc_write,
    output logic           out_iord,
    output logic           out_mem_read,
    output logic           out_mem_write,
    output logic           out_ir_write,
    output logic           out_mem_to_reg,
    output logic           out_reg_dst,
    output logic           out_reg_write,
    output logic           out_alu_src_a,
    output logic [1:0]     out_alu_src_b,
    output logic [1:0]     out_alu_op,
    output logic           out_zero_ext,
    output logic [1:0]     out_pc_source,
    output logic           out_illegal,
    output logic [3:0]     out_state
);

    state_t state;
    state_t nextState;
    logic   memReady;

    // With single-cycle memory every access completes immediately
    assign memReady = (MEM_WAIT != 0) ? in_mem_ready : 1'b1;

    mc_next_state uNextState (
        .curState  (state),
        .opcode    (in_opcode),
        .memReady  (memReady),
        .nextState (nextState)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Moore decode, before reset gating
    logic       pcWriteUncond;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       zeroExt;
    logic [1:0] pcSource;
    logic       illegal;

    always_comb begin
        pcWriteUncond = 1'b0;
        iord          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        irWrite       = 1'b0;
        memToReg      = 1'b0;
        regDst        = 1'b0;
        regWrite      = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = SRCB_REG;
        aluOp         = ALUOP_ADD;
        zeroExt       = 1'b0;
        pcSource      = PCSRC_ALU;
        illegal       = 1'b0;
        case (state)
            ST_FETCH: begin
                // PC+4 computed every cycle but only committed with the IR on the completing cycle
                memRead       = 1'b1;
                aluSrcB       = SRCB_FOUR;
                irWrite       = memReady;
                pcWriteUncond = memReady;
            end
            ST_DECODE: begin
                // speculative branch target PC + (imm<<2) lands in ALUOut
                aluSrcB = SRCB_IMM_SH;
                illegal = ~isLegalOp(in_opcode);
            end
            ST_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            ST_MEM_READ: begin
                memRead = 1'b1;
                iord    = 1'b1;
            end
            ST_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            ST_MEM_WRITE: begin
                memWrite = 1'b1;
                iord     = 1'b1;
            end
            ST_R_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            ST_BRANCH: begin
                // PC write comes from the zero-flag term below
                aluSrcA  = 1'b1;
                aluOp    = ALUOP_SUB;
                pcSource = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pcSource      = PCSRC_JUMP;
                pcWriteUncond = 1'b1;
            end
            ST_I_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_IMM;
                zeroExt = isZeroExtOp(in_opcode);
            end
            ST_I_WB: begin
                regWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Outputs are forced inactive while reset is held, independent of the state register
    assign out_pc_write   = ~rst & (pcWriteUncond | ((state == ST_BRANCH) & in_zero));
    assign out_iord       = ~rst & iord;
    assign out_mem_read   = ~rst & memRead;
    assign out_mem_write  = ~rst & memWrite;
    assign out_ir_write   = ~rst & irWrite;
    assign out_mem_to_reg = ~rst & memToReg;
    assign out_reg_dst    = ~rst & regDst;
    assign out_reg_write  = ~rst & regWrite;
    assign out_alu_src_a  = ~rst & aluSrcA;
    assign out_alu_src_b  = rst ? 2'b00 : aluSrcB;
    assign out_alu_op     = rst ? 2'b00 : aluOp;
    assign out_zero_ext   = ~rst & zeroExt;
    assign out_pc_source  = rst ? 2'b00 : pcSource;
    assign out_illegal    = ~rst & illegal;
    assign out_state      = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: scripted per-instruction cycle traces with random stalls and don't-cares.
// Latency: n/a.
// Backpressure: memory wait states injected via in_mem_ready.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in_opcode;
    logic       in_zero;
    logic       in_mem_ready;
    logic       out_pc_write, out_iord, out_mem_read, out_mem_write, out_ir_write;
    logic       out_mem_to_reg, out_reg_dst, out_reg_write, out_alu_src_a;
    logic [1:0] out_alu_src_b, out_alu_op, out_pc_source;
    logic       out_zero_ext, out_illegal;
    logic [3:0] out_state;

    always #5 clk = ~clk;

    multicycle_control #(.OPW(6), .MEM_WAIT(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_opcode      (in_opcode),
        .in_zero        (in_zero),
        .in_mem_ready   (in_mem_ready),
        .out_pc_write   (out_pc_write),
        .out_iord       (out_iord),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_ir_write   (out_ir_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_dst    (out_reg_dst),
        .out_reg_write  (out_reg_write),
        .out_alu_src_a  (out_alu_src_a),
        .out_alu_src_b  (out_alu_src_b),
        .out_alu_op     (out_alu_op),
        .out_zero_ext   (out_zero_ext),
        .out_pc_source  (out_pc_source),
        .out_illegal    (out_illegal),
        .out_state      (out_state)
    );

    // All control outputs bundled in one vector for comparison
    logic [16:0] ctlVec;
    assign ctlVec = {out_pc_write, out_iord, out_mem_read, out_mem_write, out_ir_write,
                     out_mem_to_reg, out_reg_dst, out_reg_write, out_alu_src_a,
                     out_alu_src_b, out_alu_op, out_zero_ext, out_pc_source, out_illegal};

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // One expected clock cycle: inputs to apply and outputs to see
    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        zero;
        logic [3:0]  st;
        logic [16:0] ctl;
        string       tag;
    } step_t;

    step_t q[$];
    logic [5:0] curOp;

    function automatic logic [16:0] pk(
        input logic pcw, input logic iord, input logic mr, input logic mw, input logic irw,
        input logic m2r, input logic rdst, input logic rw, input logic sa,
        input logic [1:0] sb, input logic [1:0] aop, input logic ze, input logic [1:0] ps,
        input logic ill);
        return {pcw, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, ze, ps, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic zero,
                        input logic [16:0] ctl, input string tag);
        step_t s;
        s.op = curOp; s.rdy = rdy; s.zero = zero; s.st = st; s.ctl = ctl; s.tag = tag;
        q.push_back(s);
    endtask

    // Memory phase: strobes held for every stalled cycle; only the completing cycle commits
    task automatic fetchPhase(input int stalls);
        for (int i = 0; i < stalls; i++)
            push(4'd0, 1'b0, rbit(), pk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,0,2'b00,0), "fetch_stall");
        push(4'd0, 1'b1, rbit(), pk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,0,2'b00,0), "fetch");
    endtask

    task automatic decodeStep(input logic ill);
        push(4'd1, rbit(), rbit(), pk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,2'b00,ill), "decode");
    endtask

    // Reference: whole-instruction cycle script derived from the instruction's class
    task automatic addInstr(input logic [5:0] op, input int fs, input int ms, input logic z);
        logic imm, zext;
        curOp = op;
        imm  = (op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
        zext = imm && (op != 6'b001000);
        fetchPhase(fs);
        if (op == 6'b100011 || op == 6'b101011) begin
            decodeStep(1'b0);
            push(4'd2, rbit(), rbit(), pk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,2'b00,0), "mem_addr");
            if (op == 6'b100011) begin
                for (int i = 0; i < ms; i++)
                    push(4'd3, 1'b0, rbit(), pk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0), "mem_read_stall");
                push(4'd3, 1'b1, rbit(), pk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0), "mem_read");
                push(4'd4, rbit(), rbit(), pk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,0,2'b00,0), "mem_wb");
            end else begin
                for (int i = 0; i < ms; i++)
                    push(4'd5, 1'b0, rbit(), pk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,0,2'b00,0), "mem_write_stall");
                push(4'd5, 1'b1, rbit(), pk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,0,2'b00,0), "mem_write");
            end
        end else if (op == 6'b000000) begin
            decodeStep(1'b0);
            push(4'd6, rbit(), rbit(), pk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,2'b00,0), "r_exec");
            push(4'd7, rbit(), rbit(), pk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,0,2'b00,0), "r_wb");
        end else if (op == 6'b000100) begin
            decodeStep(1'b0);
            push(4'd8, rbit(), z, pk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,0,2'b01,0), "branch");
        end else if (op == 6'b000010) begin
            decodeStep(1'b0);
            push(4'd9, rbit(), rbit(), pk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b10,0), "jump");
        end else if (imm) begin
            decodeStep(1'b0);
            push(4'd10, rbit(), rbit(), pk(0,0,0,0,0,0,0,0,1,2'b10,2'b11,zext,2'b00,0), "i_exec");
            push(4'd11, rbit(), rbit(), pk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,0,2'b00,0), "i_wb");
        end else begin
            decodeStep(1'b1);
        end
    endtask

    // Called at posedge+1; each step is checked mid-cycle, then the clock advances
    task automatic runQ();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            in_opcode    = s.op;
            in_mem_ready = s.rdy;
            in_zero      = s.zero;
            #3;
            checkVal({s.tag, "_state"}, 32'(out_state), 32'(s.st));
            checkVal({s.tag, "_ctl"},   32'(ctlVec),    32'(s.ctl));
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] opTable [10];

    initial begin
        opTable = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                    6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b111111};
        rst = 1'b1;
        in_opcode = 6'b100011;
        in_zero = 1'b1;
        in_mem_ready = 1'b1;
        curOp = 6'b000000;

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkVal("reset_state", 32'(out_state), 32'd0);
        checkVal("reset_ctl",   32'(ctlVec),    32'd0);
        rst = 1'b0;

        // Directed instruction mix
        addInstr(6'b000000, 0, 0, 1'b0);
        addInstr(6'b100011, 0, 2, 1'b0);
        addInstr(6'b000100, 0, 0, 1'b1);
        addInstr(6'b000100, 0, 0, 1'b0);
        addInstr(6'b001101, 0, 0, 1'b0);
        addInstr(6'b001000, 1, 0, 1'b0);
        addInstr(6'b111111, 0, 0, 1'b0);
        addInstr(6'b101011, 2, 1, 1'b0);
        addInstr(6'b000010, 0, 0, 1'b0);
        runQ();

        // Reset in the middle of a stalled load
        curOp = 6'b100011;
        fetchPhase(0);
        decodeStep(1'b0);
        push(4'd2, 1'b1, 1'b0, pk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,2'b00,0), "rst_mem_addr");
        runQ();
        in_mem_ready = 1'b0;
        #1;
        checkVal("pre_rst_state", 32'(out_state), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        checkVal("mid_rst_state", 32'(out_state), 32'd0);
        checkVal("mid_rst_ctl",   32'(ctlVec),    32'd0);
        in_mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checkVal("held_rst_state", 32'(out_state), 32'd0);
        checkVal("held_rst_ctl",   32'(ctlVec),    32'd0);
        rst = 1'b0;
        addInstr(6'b000000, 0, 0, 1'b0);
        runQ();

        // Random instruction stream with random wait states
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            op = opTable[$urandom_range(0, 9)];
            if (op == 6'b111111) op = 6'($urandom_range(0, 63));
            addInstr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0, rbit());
            runQ();
        end

        $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
